// File: rtl/dl_pkg.sv
// Shared state type and download address map for the ROM download transmitter.
package dl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_BYTE = 3'd1,
        ST_WRITE     = 3'd2,
        ST_GAP       = 3'd3,
        ST_FINISH    = 3'd4
    } dl_state_t;

    // Program ROM sits at the bottom, vector ROM right above it; DL_LIMIT is the first unmapped byte.
    localparam logic [31:0] PROG_ROM_BASE = 32'h0000_0000;
    localparam logic [31:0] PROG_ROM_SIZE = 32'h0000_4000;
    localparam logic [31:0] VEC_ROM_BASE  = PROG_ROM_BASE + PROG_ROM_SIZE;
    localparam logic [31:0] VEC_ROM_SIZE  = 32'h0000_1000;
    localparam logic [31:0] DL_LIMIT      = VEC_ROM_BASE + VEC_ROM_SIZE;

    function automatic logic above_limit(input logic [31:0] addr);
        return (addr >= DL_LIMIT);
    endfunction

endpackage

// File: rtl/dl_stream_tx_gap_timer.sv
// dl_gap_timer: loadable down-counter; gap_done is high during the last cycle of a loaded interval.
module dl_gap_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         gap_done
);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;
    logic         done_d;
    logic         done_q;

    // Next count: clear beats load, load beats decrement, zero holds.
    always_comb begin
        if (clr) begin
            cnt_d = {W{1'b0}};
        end else if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != {W{1'b0}}) begin
            cnt_d = cnt_q - W'(1);
        end else begin
            cnt_d = cnt_q;
        end
        done_d = (cnt_d == W'(1));
    end

    // Counter and pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= {W{1'b0}};
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign gap_done = done_q;

endmodule

// File: rtl/dl_stream_tx.sv
// ROM download transmitter: byte stream in, paced dl_wr strobes out, core held in reset meanwhile.
// Optional running checksum with compare: define DL_CHECKSUM_EN.
module dl_stream_tx
    import dl_pkg::*;
#(
    parameter int WR_GAP = 2,
    parameter int ADDR_W = 25,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic [ADDR_W-1:0] dl_addr,
    output logic [7:0]        dl_data,
    output logic              dl_wr,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
`ifdef DL_CHECKSUM_EN
    input  logic [15:0]       exp_csum,
    output logic [15:0]       csum,
    output logic              csum_err,
`endif
    output logic              range_err
);

    localparam int GAP_W = (WR_GAP < 2) ? 1 : $clog2(WR_GAP + 1);

    dl_state_t         state_d, state_q;
    logic [ADDR_W-1:0] base_d, base_q, addr_d, addr_q, cur_addr_s;
    logic [LEN_W-1:0]  len_d, len_q, count_d, count_q, count_inc_s;
    logic [7:0]        data_d, data_q;
    logic              wr_d, wr_q, done_d, done_q, busy_d, busy_q;
    logic              hold_d, hold_q, range_d, range_q;
    logic              gap_load_s, gap_clr_s, gap_done_s;
`ifdef DL_CHECKSUM_EN
    logic [15:0]       csum_d, csum_q, expc_d, expc_q;
    logic              cerr_d, cerr_q;
`endif

    dl_gap_timer #(.W(GAP_W)) u_gap (
        .clk      (clk),
        .rst      (rst),
        .clr      (gap_clr_s),
        .load     (gap_load_s),
        .load_val (GAP_W'(WR_GAP)),
        .gap_done (gap_done_s)
    );

    assign cur_addr_s  = base_q + ADDR_W'(count_q);
    assign count_inc_s = count_q + LEN_W'(1);

    // Transfer sequencing; abort overrides everything outside IDLE, including a coincident handshake.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        len_d      = len_q;
        count_d    = count_q;
        addr_d     = addr_q;
        data_d     = data_q;
        wr_d       = 1'b0;
        done_d     = 1'b0;
        busy_d     = busy_q;
        hold_d     = hold_q;
        range_d    = range_q;
        gap_load_s = 1'b0;
        gap_clr_s  = 1'b0;
`ifdef DL_CHECKSUM_EN
        csum_d     = csum_q;
        expc_d     = expc_q;
        cerr_d     = cerr_q;
`endif
        if (abort && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            busy_d    = 1'b0;
            hold_d    = 1'b0;
            gap_clr_s = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        base_d  = base_addr;
                        len_d   = length;
                        count_d = {LEN_W{1'b0}};
                        range_d = 1'b0;
                        busy_d  = 1'b1;
                        hold_d  = 1'b1;
`ifdef DL_CHECKSUM_EN
                        csum_d  = 16'h0000;
                        expc_d  = exp_csum;
                        cerr_d  = 1'b0;
`endif
                        if (length == {LEN_W{1'b0}}) begin
                            state_d = ST_FINISH;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_WAIT_BYTE;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_WAIT_BYTE: begin
                    if (s_valid) begin
                        data_d  = s_data;
                        addr_d  = cur_addr_s;
                        wr_d    = 1'b1;
                        range_d = range_q | above_limit(32'(cur_addr_s));
`ifdef DL_CHECKSUM_EN
                        csum_d  = csum_q + {8'h00, s_data};
`endif
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_WAIT_BYTE;
                    end
                end
                ST_WRITE: begin
                    count_d = count_inc_s;
                    if (WR_GAP > 0) begin
                        state_d    = ST_GAP;
                        gap_load_s = 1'b1;
                    end else if (count_inc_s == len_q) begin
                        state_d = ST_FINISH;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_WAIT_BYTE;
                    end
                end
                ST_GAP: begin
                    if (!gap_done_s) begin
                        state_d = ST_GAP;
                    end else if (count_q == len_q) begin
                        state_d = ST_FINISH;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_WAIT_BYTE;
                    end
                end
                ST_FINISH: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    hold_d  = 1'b0;
`ifdef DL_CHECKSUM_EN
                    cerr_d  = (csum_q != expc_q);
`endif
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    hold_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; reset drops everything, including a half-issued write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            base_q  <= {ADDR_W{1'b0}};
            len_q   <= {LEN_W{1'b0}};
            count_q <= {LEN_W{1'b0}};
            addr_q  <= {ADDR_W{1'b0}};
            data_q  <= 8'h00;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            hold_q  <= 1'b0;
            range_q <= 1'b0;
`ifdef DL_CHECKSUM_EN
            csum_q  <= 16'h0000;
            expc_q  <= 16'h0000;
            cerr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            hold_q  <= hold_d;
            range_q <= range_d;
`ifdef DL_CHECKSUM_EN
            csum_q  <= csum_d;
            expc_q  <= expc_d;
            cerr_q  <= cerr_d;
`endif
        end
    end

    assign s_ready   = (state_q == ST_WAIT_BYTE);
    assign dl_addr   = addr_q;
    assign dl_data   = data_q;
    assign dl_wr     = wr_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign core_hold = hold_q;
    assign range_err = range_q;
`ifdef DL_CHECKSUM_EN
    assign csum      = csum_q;
    assign csum_err  = cerr_q;
`endif

endmodule

// File: tb/tb_dl_stream_tx.sv
// Self-checking bench for dl_stream_tx: timestamp-based reference model compared every cycle,
// plus literal checks of the documented timing, addressing, abort and reset cases.
module tb_dl_stream_tx;

    localparam int WR_GAP = 2;

    logic        clk = 1'b0;
    logic        rst, start, abort, s_valid;
    logic [24:0] base_addr;
    logic [15:0] length;
    logic [7:0]  s_data;
    logic        s_ready, dl_wr, core_hold, busy, done, range_err;
    logic [24:0] dl_addr;
    logic [7:0]  dl_data;
`ifdef DL_CHECKSUM_EN
    logic [15:0] exp_csum, csum;
    logic        csum_err;
`endif

    dl_stream_tx #(.WR_GAP(WR_GAP), .ADDR_W(25), .LEN_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .base_addr(base_addr), .length(length),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .dl_addr(dl_addr), .dl_data(dl_data), .dl_wr(dl_wr),
        .core_hold(core_hold), .busy(busy), .done(done),
`ifdef DL_CHECKSUM_EN
        .exp_csum(exp_csum), .csum(csum), .csum_err(csum_err),
`endif
        .range_err(range_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // reference model state (timestamps in cycles; -1 = no event pending)
    bit          m_act = 1'b0;
    logic [24:0] m_base;
    int          m_len, m_k;
    int          ready_at = -1, done_at = -1, end_at = -1;
    bit          e_ready = 1'b0, e_wr = 1'b0, e_done = 1'b0, e_busy = 1'b0, e_range = 1'b0;
    logic [24:0] e_addr = 25'd0;
    logic [7:0]  e_data = 8'd0;
    logic [15:0] m_csum = 16'd0, m_exp = 16'd0;
    bit          e_cerr = 1'b0;

    // observation log for literal checks
    int          wr_cnt, done_cnt, done_cyc, first_hs, ready_cnt;
    int          wr_cyc [0:15];
    logic [24:0] wr_addr [0:15];
    logic [7:0]  wr_dat [0:15];
    logic        wr_rng [0:15];
    logic [7:0]  tx [0:15];
    int          st_cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        bit hs;
        hs = e_ready && (s_valid === 1'b1);
        e_wr = 1'b0;
        e_done = 1'b0;
        if (rst) begin
            m_act = 1'b0; e_ready = 1'b0; e_busy = 1'b0; e_range = 1'b0;
            e_addr = 25'd0; e_data = 8'd0; m_csum = 16'd0; m_exp = 16'd0; e_cerr = 1'b0;
            ready_at = -1; done_at = -1; end_at = -1;
        end else if (!m_act) begin
            if (start) begin
                m_act = 1'b1; m_base = base_addr; m_len = int'(length); m_k = 0;
                e_range = 1'b0; e_busy = 1'b1; m_csum = 16'd0; e_cerr = 1'b0;
`ifdef DL_CHECKSUM_EN
                m_exp = exp_csum;
`endif
                if (m_len == 0) begin
                    e_done = 1'b1; end_at = cyc + 1; e_ready = 1'b0;
                end else begin
                    e_ready = 1'b1;
                end
            end
        end else if (abort) begin
            m_act = 1'b0; e_ready = 1'b0; e_busy = 1'b0;
            ready_at = -1; done_at = -1; end_at = -1;
        end else if (hs) begin
            e_ready = 1'b0; e_wr = 1'b1;
            e_addr = m_base + 25'(m_k);
            e_data = s_data;
            if (e_addr >= 25'h0005000) e_range = 1'b1;
            m_csum = m_csum + {8'h00, s_data};
            m_k++;
            if (m_k == m_len) begin
                done_at = cyc + 1 + WR_GAP; end_at = done_at + 1;
            end else begin
                ready_at = cyc + 1 + WR_GAP;
            end
        end else begin
            if (cyc == ready_at) begin e_ready = 1'b1; ready_at = -1; end
            if (cyc == done_at) begin e_done = 1'b1; done_at = -1; end
            if (cyc == end_at) begin
                m_act = 1'b0; e_busy = 1'b0; end_at = -1;
                e_cerr = (m_csum != m_exp);
            end
        end
    endtask

    // Monitor: advance the model at each edge, compare and log mid-cycle.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            model_step();
            @(negedge clk);
            chk("s_ready", {31'd0, s_ready}, {31'd0, e_ready});
            chk("dl_wr", {31'd0, dl_wr}, {31'd0, e_wr});
            chk("done", {31'd0, done}, {31'd0, e_done});
            chk("busy", {31'd0, busy}, {31'd0, e_busy});
            chk("core_hold", {31'd0, core_hold}, {31'd0, e_busy});
            chk("range_err", {31'd0, range_err}, {31'd0, e_range});
            chk("dl_addr", {7'd0, dl_addr}, {7'd0, e_addr});
            chk("dl_data", {24'd0, dl_data}, {24'd0, e_data});
`ifdef DL_CHECKSUM_EN
            chk("csum", {16'd0, csum}, {16'd0, m_csum});
            chk("csum_err", {31'd0, csum_err}, {31'd0, e_cerr});
`endif
            if (dl_wr === 1'b1 && wr_cnt < 16) begin
                wr_cyc[wr_cnt] = cyc; wr_addr[wr_cnt] = dl_addr;
                wr_dat[wr_cnt] = dl_data; wr_rng[wr_cnt] = range_err;
                wr_cnt++;
            end
            if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
            if (s_ready === 1'b1) ready_cnt++;
            if (s_ready === 1'b1 && s_valid === 1'b1 && first_hs < 0) first_hs = cyc;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cycle %0d got timeout expected finish", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_log();
        wr_cnt = 0; done_cnt = 0; done_cyc = -1; first_hs = -1; ready_cnt = 0;
    endtask

    task automatic do_start(input logic [24:0] b, input logic [15:0] n);
        base_addr = b; length = n; start = 1'b1; st_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    // mode 0: valid held high, 1: random valid, 2: 1-0-0-1 toggle
    task automatic feed(input int n, input int mode);
        int idx = 0;
        int t = 0;
        while (idx < n && t < 1000) begin
            case (mode)
                0:       s_valid = 1'b1;
                1:       s_valid = 1'($urandom_range(0, 1));
                default: s_valid = ((t % 4) == 0) || ((t % 4) == 3);
            endcase
            s_data = tx[idx];
            @(negedge clk);
            if (s_valid && s_ready) idx++;
            @(posedge clk);
            #2;
            t++;
        end
        s_valid = 1'b0;
        chk("feed_complete", 32'(idx), 32'(n));
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy !== 1'b0 && t < 500) begin
            tick();
            t++;
        end
        chk("idle_reached", {31'd0, busy}, 32'd0);
        tick();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        base_addr = 25'd0; length = 16'd0;
`ifdef DL_CHECKSUM_EN
        exp_csum = 16'h0000;
`endif
        clear_log();
        repeat (3) tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_addr", {7'd0, dl_addr}, 32'd0);
        chk("rst_ready", {31'd0, s_ready}, 32'd0);
        rst = 1'b0;
        tick();

        // basic transfer, bytes A0..A3
        clear_log();
        for (int i = 0; i < 4; i++) tx[i] = 8'hA0 + 8'(i);
        do_start(25'h0000000, 16'd4);
        feed(4, 0);
        wait_idle();
        chk("basic_wr_cnt", 32'(wr_cnt), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("basic_wr_cycle", 32'(wr_cyc[i] - first_hs), 32'(1 + 4 * i));
            chk("basic_addr", {7'd0, wr_addr[i]}, 32'(i));
            chk("basic_data", {24'd0, wr_dat[i]}, 32'(8'hA0 + 8'(i)));
        end
        chk("basic_done_cycle", 32'(done_cyc - first_hs), 32'd16);

        // zero length
        clear_log();
        do_start(25'h0000123, 16'd0);
        wait_idle();
        chk("zero_done_cycle", 32'(done_cyc - st_cyc), 32'd1);
        chk("zero_wr_cnt", 32'(wr_cnt), 32'd0);
        chk("zero_ready_cnt", 32'(ready_cnt), 32'd0);

        // range crossing at 0x5000
        clear_log();
        for (int i = 0; i < 3; i++) tx[i] = 8'($urandom_range(0, 255));
        do_start(25'h0004FFE, 16'd3);
        feed(3, 0);
        wait_idle();
        chk("range_addr0", {7'd0, wr_addr[0]}, 32'h4FFE);
        chk("range_addr2", {7'd0, wr_addr[2]}, 32'h5000);
        chk("range_flag1", {31'd0, wr_rng[1]}, 32'd0);
        chk("range_flag2", {31'd0, wr_rng[2]}, 32'd1);
        chk("range_sticky", {31'd0, range_err}, 32'd1);

        // wrap at the top of the address space
        clear_log();
        do_start(25'h1FFFFFF, 16'd2);
        feed(2, 0);
        wait_idle();
        chk("wrap_addr0", {7'd0, wr_addr[0]}, 32'h1FFFFFF);
        chk("wrap_addr1", {7'd0, wr_addr[1]}, 32'h0);

        // abort during GAP after 2 of 5 bytes
        clear_log();
        for (int i = 0; i < 5; i++) tx[i] = 8'h10 + 8'(i);
        do_start(25'h0000100, 16'd5);
        feed(2, 0);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hold", {31'd0, core_hold}, 32'd0);
        repeat (10) tick();
        chk("abort_wr_cnt", 32'(wr_cnt), 32'd2);
        chk("abort_done_cnt", 32'(done_cnt), 32'd0);

        // abort coincident with a handshake
        clear_log();
        do_start(25'h0000200, 16'd3);
        s_valid = 1'b1; s_data = 8'h5A; abort = 1'b1;
        tick();
        s_valid = 1'b0; abort = 1'b0;
        repeat (6) tick();
        chk("abort_hs_wr_cnt", 32'(wr_cnt), 32'd0);
        chk("abort_hs_done", 32'(done_cnt), 32'd0);

        // reset in WAIT_BYTE, then a normal run
        do_start(25'h0000300, 16'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("srst_busy", {31'd0, busy}, 32'd0);
        chk("srst_addr", {7'd0, dl_addr}, 32'd0);
        chk("srst_data", {24'd0, dl_data}, 32'd0);
        chk("srst_ready", {31'd0, s_ready}, 32'd0);
        clear_log();
        tx[0] = 8'h77; tx[1] = 8'h88;
        do_start(25'h0000010, 16'd2);
        feed(2, 0);
        wait_idle();
        chk("post_rst_wr_cnt", 32'(wr_cnt), 32'd2);
        chk("post_rst_addr1", {7'd0, wr_addr[1]}, 32'h11);

        // back-pressure with 1-0-0-1 valid pattern
        clear_log();
        for (int i = 0; i < 4; i++) tx[i] = 8'hC0 + 8'(i);
        do_start(25'h0000040, 16'd4);
        feed(4, 2);
        wait_idle();
        chk("bp_wr_cnt", 32'(wr_cnt), 32'd4);
        for (int i = 0; i < 4; i++) chk("bp_data", {24'd0, wr_dat[i]}, {24'd0, tx[i]});

        // random transfers
        for (int r = 0; r < 6; r++) begin
            int n;
            logic [24:0] b;
            n = $urandom_range(1, 6);
            b = 25'($urandom);
            clear_log();
            for (int i = 0; i < n; i++) tx[i] = 8'($urandom_range(0, 255));
            do_start(b, 16'(n));
            feed(n, 1);
            wait_idle();
            chk("rand_wr_cnt", 32'(wr_cnt), 32'(n));
            for (int i = 0; i < n; i++) begin
                chk("rand_addr", {7'd0, wr_addr[i]}, {7'd0, b + 25'(i)});
                chk("rand_data", {24'd0, wr_dat[i]}, {24'd0, tx[i]});
            end
        end

`ifdef DL_CHECKSUM_EN
        clear_log();
        tx[0] = 8'hFF; tx[1] = 8'h01;
        exp_csum = 16'h0101;
        do_start(25'h0000000, 16'd2);
        feed(2, 0);
        wait_idle();
        chk("csum_value", {16'd0, csum}, 32'h0100);
        chk("csum_err_set", {31'd0, csum_err}, 32'd1);
        exp_csum = 16'h0100;
        do_start(25'h0000000, 16'd2);
        feed(2, 0);
        wait_idle();
        chk("csum_err_clear", {31'd0, csum_err}, 32'd0);
`endif

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dl_stream_tx.md
Name: dl_stream_tx

Overview:
Transmitter end of the ROM download bus that the arcade top consumes (dl_addr / dl_data / dl_wr).
- Accepts a byte stream over a valid/ready handshake and turns it into paced, single-cycle write strobes at incrementing addresses.
- Covers the program ROM (0x0000-0x3FFF) and the vector ROM (0x4000-0x4FFF).
- Holds the game core in reset for the whole transfer, so CPU vector-RAM writes never contend with download writes.

Parameters:
- WR_GAP, 2, idle cycles inserted after each dl_wr pulse (0 allowed); keeps dpram port A writes spaced.
- ADDR_W, 25, width of dl_addr and base_addr.
- LEN_W, 16, width of the length input.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start  in  1  request a transfer; sampled only in IDLE
- abort  in  1  cancel the transfer in progress
- base_addr  in  ADDR_W  first download address
- length  in  LEN_W  number of bytes to transfer
- s_valid  in  1  stream byte valid
- s_data  in  8  stream byte
- s_ready  out  1  block can accept a byte
- dl_addr  out  ADDR_W  download address
- dl_data  out  8  download byte
- dl_wr  out  1  download write strobe
- core_hold  out  1  drive into the core reset
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- range_err  out  1  sticky: a write landed at or above 0x5000

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE.
  - All outputs 0, including dl_addr and dl_data.
  - Byte counter and gap counter cleared.
  - Reset mid-transfer takes the same path; a partially issued dl_wr is not completed.
- States:
  - IDLE.
  - WAIT_BYTE.
  - WRITE.
  - GAP.
  - FINISH.
- IDLE:
  - start=1 → latch base_addr and length, clear range_err, set busy=1 and core_hold=1.
  - Next state is WAIT_BYTE, or FINISH if length==0.
- WAIT_BYTE:
  - s_ready=1 combinationally in this state only.
  - On s_valid&&s_ready, register dl_data<=s_data and dl_addr<=base+count, then go to WRITE.
- WRITE:
  - dl_wr=1 for exactly one cycle; the cycle after a handshake at cycle N is N+1.
  - Increment count.
  - If addr>=0x5000, set range_err. The write is still issued.
  - Next state is GAP if WR_GAP>0.
  - Otherwise next state is WAIT_BYTE, or FINISH if count reaches length.
- GAP:
  - Count WR_GAP cycles.
  - Then go to WAIT_BYTE, or FINISH if count==length.
  - dl_addr and dl_data hold stable from the WRITE cycle through the end of GAP.
- FINISH:
  - done=1 for one cycle.
  - busy and core_hold drop on the following cycle; state returns to IDLE.
- Addressing: dl_addr = base + count, modulo 2^ADDR_W; it wraps silently at the top of the space.
- abort:
  - Honoured in any non-IDLE state: state goes to IDLE on the next edge, with no further dl_wr and no done pulse.
  - busy and core_hold drop on that edge.
  - If abort arrives in the same cycle as a handshake, abort wins: the byte is consumed and discarded.
- start while busy is ignored. start and abort together in IDLE: abort is a no-op, so the transfer starts.
- Maximum throughput is one byte per (2+WR_GAP) cycles.

Optional Feature:
- Macro: DL_CHECKSUM_EN.
- Defined:
  - Add output csum (16 bits), a running modular sum of written bytes, cleared on start.
  - Add input exp_csum (16 bits), sampled at start.
  - Add output csum_err, set in FINISH if csum!=exp_csum and held until the next start.
- Undefined: none of these ports or logic exist.

Decomposition:
- Package dl_pkg holds:
  - The state enum dl_state_t.
  - Region constants PROG_ROM_BASE=0x0000, PROG_ROM_SIZE=0x4000, VEC_ROM_BASE=0x4000, VEC_ROM_SIZE=0x1000, DL_LIMIT=0x5000.
- One sub-module, dl_gap_timer: a loadable down-counter producing a gap_done pulse. Everything else lives in dl_stream_tx.

Test Plan:
- Basic transfer:
  - Stimulus: WR_GAP=2, base=0x0000, length=4, bytes A0..A3 with s_valid held high.
  - Required: dl_wr pulses at cycles 1, 5, 9 and 13 after the first handshake; addr/data pairs 0/A0 .. 3/A3; done one cycle after the last gap; core_hold high throughout.
- Zero length:
  - Stimulus: length=0.
  - Required: no dl_wr and no s_ready; done pulses the cycle after start; busy returns to 0 one cycle later.
- Range and wrap:
  - Stimulus: base=0x4FFE, length=3.
  - Required: writes to 0x4FFE, 0x4FFF and 0x5000; range_err rises at the 0x5000 write and stays set. A separate run with base=0x1FFFFFF and length=2 must show writes to 0x1FFFFFF then 0x0000000.
- Abort:
  - Stimulus: abort during GAP after 2 of 5 bytes.
  - Required: no further dl_wr, no done, busy and core_hold 0 on the next edge. Abort coincident with a handshake must produce no dl_wr.
- Reset:
  - Stimulus: rst pulse in WAIT_BYTE.
  - Required: all outputs 0 on the next edge; a following start runs normally.
- Back-pressure and checksum:
  - Stimulus: s_valid toggled 1-0-0-1.
  - Required: s_ready is high only in WAIT_BYTE and no bytes are dropped.
  - With DL_CHECKSUM_EN defined, bytes 0xFF,0x01 give csum=0x0100; exp_csum=0x0101 gives csum_err=1.
